// File: rtl/serial_port_responder.sv
// UART responder: processor byte port <-> 8N1 serial line through TX/RX FIFOs. Loopback via SERIAL_LOOPBACK_EN.
// Latency: TX line falls 2 edges after a write to an idle transmitter; an RX byte appears one edge after its stop-bit midpoint.
// Backpressure: writes are dropped while serial_ready_out=0; RX bytes arriving at a full FIFO are dropped and flagged.

module serial_port_responder_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop_rdy && !empty;
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign do_push  = push_vld && (!full || do_pop);
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module serial_port_responder #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] serial_data_in,
    input  logic       serial_wren_in,
    input  logic       serial_rden_in,
    output logic [7:0] serial_data_out,
    output logic       serial_valid_out,
    output logic       serial_ready_out,
    input  logic       uart_rx_in,
    output logic       uart_tx_out,
    output logic       frame_err_out,
    output logic       overrun_out
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [7:0] tx_head;
    logic       tx_empty, tx_full, tx_pop;
    logic       rx_full, rx_empty, rx_push;

    state_t     tx_state, tx_state_nx;
    logic [CW-1:0] tx_cnt, tx_cnt_nx;
    logic [2:0] tx_bit, tx_bit_nx;
    logic [7:0] tx_shreg, tx_shreg_nx;
    logic       tx_line, tx_line_nx;

    state_t     rx_state, rx_state_nx;
    logic [CW-1:0] rx_cnt, rx_cnt_nx;
    logic [2:0] rx_bit, rx_bit_nx;
    logic [7:0] rx_shreg, rx_shreg_nx;
    logic       rx_line, set_ferr, set_ovr;
    logic       frame_err_q, overrun_q;

    assign serial_ready_out = !tx_full;
    assign serial_valid_out = !rx_empty;
    assign frame_err_out    = frame_err_q;
    assign overrun_out      = overrun_q;

    serial_port_responder_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .push_vld(serial_wren_in && serial_ready_out), .push_dat(serial_data_in),
        .pop_rdy(tx_pop), .head_dat(tx_head), .empty(tx_empty), .full(tx_full)
    );

    serial_port_responder_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .push_vld(rx_push), .push_dat(rx_shreg),
        .pop_rdy(serial_rden_in), .head_dat(serial_data_out), .empty(rx_empty), .full(rx_full)
    );

    // The line is registered from the current state, so it trails the FSM by one edge.
    always_comb begin
        tx_state_nx = tx_state;
        tx_cnt_nx   = tx_cnt + 1'b1;
        tx_bit_nx   = tx_bit;
        tx_shreg_nx = tx_shreg;
        tx_pop      = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_nx = '0;
                if (!tx_empty) begin
                    tx_pop      = 1'b1;
                    tx_shreg_nx = tx_head;
                    tx_state_nx = S_START;
                end
            end
            S_START: if (tx_cnt == LAST) begin
                tx_cnt_nx   = '0;
                tx_bit_nx   = '0;
                tx_state_nx = S_DATA;
            end
            S_DATA: if (tx_cnt == LAST) begin
                tx_cnt_nx   = '0;
                tx_shreg_nx = {1'b0, tx_shreg[7:1]};
                if (tx_bit == 3'd7) tx_state_nx = S_STOP;
                else                tx_bit_nx   = tx_bit + 1'b1;
            end
            S_STOP: if (tx_cnt == LAST) begin
                tx_cnt_nx = '0;
                if (!tx_empty) begin
                    tx_pop      = 1'b1;
                    tx_shreg_nx = tx_head;
                    tx_state_nx = S_START;
                end else begin
                    tx_state_nx = S_IDLE;
                end
            end
            default: tx_state_nx = S_IDLE;
        endcase
        case (tx_state)
            S_START: tx_line_nx = 1'b0;
            S_DATA:  tx_line_nx = tx_shreg[0];
            default: tx_line_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nx;
            tx_cnt   <= tx_cnt_nx;
            tx_bit   <= tx_bit_nx;
            tx_shreg <= tx_shreg_nx;
            tx_line  <= tx_line_nx;
        end
    end

`ifdef SERIAL_LOOPBACK_EN
    assign rx_line     = tx_line;
    assign uart_tx_out = 1'b1;
`else
    logic rx_s1, rx_s2;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx_in;
            rx_s2 <= rx_s1;
        end
    end
    assign rx_line     = rx_s2;
    assign uart_tx_out = tx_line;
`endif

    always_comb begin
        rx_state_nx = rx_state;
        rx_cnt_nx   = rx_cnt + 1'b1;
        rx_bit_nx   = rx_bit;
        rx_shreg_nx = rx_shreg;
        rx_push     = 1'b0;
        set_ferr    = 1'b0;
        set_ovr     = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_nx = '0;
                if (!rx_line) rx_state_nx = S_START;
            end
            // Half a bit in: confirm the start bit, then every full bit lands on a midpoint.
            S_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_nx = '0;
                if (rx_line) rx_state_nx = S_IDLE;
                else begin
                    rx_bit_nx   = '0;
                    rx_state_nx = S_DATA;
                end
            end
            S_DATA: if (rx_cnt == LAST) begin
                rx_cnt_nx   = '0;
                rx_shreg_nx = {rx_line, rx_shreg[7:1]};
                if (rx_bit == 3'd7) rx_state_nx = S_STOP;
                else                rx_bit_nx   = rx_bit + 1'b1;
            end
            S_STOP: if (rx_cnt == LAST) begin
                rx_cnt_nx   = '0;
                rx_state_nx = S_IDLE;
                if (!rx_line)                          set_ferr = 1'b1;
                else if (rx_full && !serial_rden_in)   set_ovr  = 1'b1;
                else                                   rx_push  = 1'b1;
            end
            default: rx_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state    <= S_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_shreg    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_state    <= rx_state_nx;
            rx_cnt      <= rx_cnt_nx;
            rx_bit      <= rx_bit_nx;
            rx_shreg    <= rx_shreg_nx;
            if (set_ferr) frame_err_q <= 1'b1;
            if (set_ovr)  overrun_q   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_serial_port_responder.sv
// Directed bench for serial_port_responder at CLKS_PER_BIT=4, FIFO_DEPTH=8; loopback build checked when SERIAL_LOOPBACK_EN is set.
module tb_serial_port_responder;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] serial_data_in = 8'h00;
    logic       serial_wren_in = 1'b0;
    logic       serial_rden_in = 1'b0;
    logic [7:0] serial_data_out;
    logic       serial_valid_out, serial_ready_out;
    logic       uart_rx_in = 1'b1;
    logic       uart_tx_out, frame_err_out, overrun_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_port_responder #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .serial_data_in(serial_data_in), .serial_wren_in(serial_wren_in),
        .serial_rden_in(serial_rden_in), .serial_data_out(serial_data_out),
        .serial_valid_out(serial_valid_out), .serial_ready_out(serial_ready_out),
        .uart_rx_in(uart_rx_in), .uart_tx_out(uart_tx_out),
        .frame_err_out(frame_err_out), .overrun_out(overrun_out)
    );

    typedef struct {
        logic       is_tx;
        logic [7:0] dat;
        logic       stop_bit;
        logic [9:0] exp_frame;   // TX: line bits, index 0 = start bit
        logic       exp_vld;
        logic [7:0] exp_dat;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_tx"},    {31'd0, uart_tx_out}, 32'd1);
        check({nm, "_rdy"},   {31'd0, serial_ready_out}, 32'd1);
        check({nm, "_vld"},   {31'd0, serial_valid_out}, 32'd0);
        check({nm, "_dat"},   {24'd0, serial_data_out}, 32'h00);
        check({nm, "_ferr"},  {31'd0, frame_err_out}, 32'd0);
        check({nm, "_ovr"},   {31'd0, overrun_out}, 32'd0);
    endtask

    task automatic expect_frame(input logic [9:0] f, input string nm);
        for (int k = 0; k < 40; k++) begin
            tick();
            check(nm, {31'd0, uart_tx_out}, {31'd0, f[k/4]});
        end
    endtask

    // Write one byte into an idle transmitter and follow its frame on the line.
    task automatic tx_byte(input logic [7:0] b, input logic [9:0] f);
        serial_data_in = b;
        serial_wren_in = 1'b1;
        tick();
        serial_wren_in = 1'b0;
        tick();
        check("tx_before_start", {31'd0, uart_tx_out}, 32'd1);
        expect_frame(f, "tx_frame");
        repeat (4) tick();
        check("tx_idle_after", {31'd0, uart_tx_out}, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx_in = bits[i];
            repeat (4) tick();
        end
        uart_rx_in = 1'b1;
        repeat (6) tick();
    endtask

    task automatic pop_rx();
        serial_rden_in = 1'b1;
        tick();
        serial_rden_in = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

`ifdef SERIAL_LOOPBACK_EN
    initial begin : loopback_test
        bit tx_ok;
        bit got;
        tx_ok = 1'b1;
        got   = 1'b0;
        repeat (3) tick();
        check_reset_vals("lb_reset");
        reset = 1'b1;
        tick();
        serial_data_in = 8'h5A;
        serial_wren_in = 1'b1;
        tick();
        serial_wren_in = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            tick();
            if (uart_tx_out !== 1'b1) tx_ok = 1'b0;
            if (serial_valid_out === 1'b1) got = 1'b1;
        end
        check("lb_valid_in_budget", {31'd0, got}, 32'd1);
        check("lb_data", {24'd0, serial_data_out}, 32'h5A);
        check("lb_tx_held_high", {31'd0, tx_ok}, 32'd1);
        check("lb_no_ferr", {31'd0, frame_err_out}, 32'd0);
        pop_rx();
        check("lb_pop_empty", {31'd0, serial_valid_out}, 32'd0);
        repeat (6) tick();
        check("lb_ovr", {31'd0, overrun_out}, 32'd0);
        check("lb_rdy", {31'd0, serial_ready_out}, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`else
    initial begin : main_test
        bit line_ok;
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 10'h34A, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 8'h00, 1'b1, 10'h200, 1'b0, 8'h00, 1'b0};
        vecs[2] = '{1'b1, 8'hFF, 1'b1, 10'h3FE, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1'b0, 8'h3C, 1'b1, 10'h000, 1'b1, 8'h3C, 1'b0};
        vecs[4] = '{1'b0, 8'h81, 1'b1, 10'h000, 1'b1, 8'h81, 1'b0};
        vecs[5] = '{1'b0, 8'h55, 1'b0, 10'h000, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{1'b0, 8'hC3, 1'b1, 10'h000, 1'b1, 8'hC3, 1'b1};

        repeat (3) tick();
        check_reset_vals("por");
        reset = 1'b1;
        repeat (2) tick();
        check_reset_vals("after_release");

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].is_tx) begin
                tx_byte(vecs[v].dat, vecs[v].exp_frame);
            end else begin
                send_frame(vecs[v].dat, vecs[v].stop_bit);
                check("rx_valid", {31'd0, serial_valid_out}, {31'd0, vecs[v].exp_vld});
                check("rx_ferr", {31'd0, frame_err_out}, {31'd0, vecs[v].exp_ferr});
                if (vecs[v].exp_vld) begin
                    check("rx_data", {24'd0, serial_data_out}, {24'd0, vecs[v].exp_dat});
                    pop_rx();
                    check("rx_valid_after_pop", {31'd0, serial_valid_out}, 32'd0);
                end
            end
        end
        check("ovr_quiet", {31'd0, overrun_out}, 32'd0);

        // Reset in the middle of a TX frame with an RX byte pending and frame_err set.
        send_frame(8'h99, 1'b1);
        check("pre_rst_valid", {31'd0, serial_valid_out}, 32'd1);
        serial_data_in = 8'h00;
        serial_wren_in = 1'b1;
        tick();
        serial_wren_in = 1'b0;
        repeat (12) tick();
        check("pre_rst_line_low", {31'd0, uart_tx_out}, 32'd0);
        #2 reset = 1'b0;
        #1 check_reset_vals("mid_frame_rst");
        repeat (3) tick();
        reset = 1'b1;
        line_ok = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (uart_tx_out !== 1'b1 || serial_valid_out !== 1'b0) line_ok = 1'b0;
        end
        check("no_frame_after_rst", {31'd0, line_ok}, 32'd1);

        // Ten writes on consecutive edges: nine accepted and sent back-to-back.
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    serial_data_in = 8'h10 + 8'(i);
                    serial_wren_in = 1'b1;
                    tick();
                    if (i == 7) check("full_rdy_after8", {31'd0, serial_ready_out}, 32'd1);
                    if (i == 8) check("full_rdy_after9", {31'd0, serial_ready_out}, 32'd0);
                end
                serial_wren_in = 1'b0;
            end
            begin
                tick();
                tick();
                check("full_before_start", {31'd0, uart_tx_out}, 32'd1);
                for (int n = 0; n < 9; n++) begin
                    logic [7:0] eb;
                    eb = 8'h10 + 8'(n);
                    expect_frame({1'b1, eb, 1'b0}, "full_frame");
                end
            end
        join
        line_ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (uart_tx_out !== 1'b1) line_ok = 1'b0;
        end
        check("tenth_dropped", {31'd0, line_ok}, 32'd1);
        check("full_rdy_drained", {31'd0, serial_ready_out}, 32'd1);

        // Nine good frames without reads: eight stored, ninth flagged as overrun.
        for (int i = 0; i < 9; i++) begin
            send_frame(8'hA0 + 8'(i), 1'b1);
            if (i == 7) check("ovr_after8", {31'd0, overrun_out}, 32'd0);
        end
        check("ovr_after9", {31'd0, overrun_out}, 32'd1);
        check("ovr_ferr_clear", {31'd0, frame_err_out}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            check("ovr_valid", {31'd0, serial_valid_out}, 32'd1);
            check("ovr_order", {24'd0, serial_data_out}, {24'd0, 8'hA0 + 8'(i)});
            pop_rx();
        end
        check("ovr_drained", {31'd0, serial_valid_out}, 32'd0);
        check("ovr_sticky", {31'd0, overrun_out}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
`endif
endmodule
